// File: rtl/key_event_ctrl.sv
// key_event_ctrl: PS/2 scan-code sequencer tracking F0/E0 prefixes and matching four keys.
// Optional feature: define KEY_EVENT_EXT_EN to decode E0-extended keys and honour EXT_MASK.
module key_event_ctrl #(
    parameter logic [7:0]  KEY0     = 8'h3C,
    parameter logic [7:0]  KEY1     = 8'h1C,
    parameter logic [7:0]  KEY2     = 8'h23,
    parameter logic [7:0]  KEY3     = 8'h2D,
    parameter logic [3:0]  EXT_MASK = 4'b0000,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [3:0] flag_clr,
    output logic [3:0] key_down,
    output logic [3:0] key_press,
    output logic [3:0] key_flag,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    localparam logic [3:0][7:0] KEYS = {KEY3, KEY2, KEY1, KEY0};
`ifdef KEY_EVENT_EXT_EN
    localparam logic [3:0] XMASK = EXT_MASK;
`else
    localparam logic [3:0] XMASK = EXT_MASK & 4'b0000;
`endif
    state_t      state, state_nx;
    logic [15:0] cnt;
    logic        is_f0, is_e0, code_ev, brk, ext, perr, tmo;
    logic [3:0]  hit, make, brk_hit, press_nx;
    assign is_f0 = rx_data == 8'hF0;
    assign is_e0 = rx_data == 8'hE0;
    // Counter holds cycles-since-byte minus one, so err lands TIMEOUT cycles after the byte.
    assign tmo   = state != IDLE && cnt == TIMEOUT - 16'd2;
    always_ff @(posedge clock)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (rx_valid || state_nx == IDLE) ? '0 : cnt + 16'd1;
        end
    always_comb begin
        state_nx = state;
        code_ev  = 1'b0;
        brk      = 1'b0;
        ext      = 1'b0;
        perr     = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (is_f0) state_nx = BRK;
`ifdef KEY_EVENT_EXT_EN
                    else if (is_e0) state_nx = EXT;
`else
                    else if (is_e0) state_nx = IDLE;
`endif
                    else code_ev = 1'b1;
                end
                BRK: begin
                    state_nx = IDLE;
                    perr     = is_f0 || is_e0;
                    code_ev  = !(is_f0 || is_e0);
                    brk      = 1'b1;
                end
`ifdef KEY_EVENT_EXT_EN
                EXT: begin
                    state_nx = is_f0 ? EXT_BRK : IDLE;
                    perr     = is_e0;
                    code_ev  = !(is_f0 || is_e0);
                    ext      = 1'b1;
                end
                EXT_BRK: begin
                    state_nx = IDLE;
                    perr     = is_f0 || is_e0;
                    code_ev  = !(is_f0 || is_e0);
                    brk      = 1'b1;
                    ext      = 1'b1;
                end
`endif
                default: state_nx = IDLE;
            endcase
        end else if (tmo) begin
            state_nx = IDLE;
            perr     = 1'b1;
        end
    end
    always_comb begin
        hit = '0;
        for (int i = 0; i < 4; i++)
            hit[i] = code_ev && rx_data == KEYS[i] && ext == XMASK[i];
        make     = brk ? 4'b0000 : hit;
        brk_hit  = brk ? hit : 4'b0000;
        press_nx = make & ~key_down;
    end
    always_ff @(posedge clock)
        if (reset) begin
            key_down  <= '0;
            key_press <= '0;
            key_flag  <= '0;
            err       <= 1'b0;
        end else begin
            key_down  <= (key_down | make) & ~brk_hit;
            key_press <= press_nx;
            key_flag  <= (key_flag & ~flag_clr) | press_nx;
            err       <= perr;
        end
endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Scan-code sequencer sitting between the PS/2 byte receiver and the game/control logic. Consumes received bytes, tracks make/break/extended prefixes with a state machine, and matches completed codes against four parameterised keys. Produces per-key held level, single-cycle press pulse, and sticky event flag with per-key clear. Replaces the per-key single-code filters with one sequenced controller.

## Interface
- `KEY0`, default 8'h3C, scan code of key 0
- `KEY1`, default 8'h1C, scan code of key 1
- `KEY2`, default 8'h23, scan code of key 2
- `KEY3`, default 8'h2D, scan code of key 3
- `EXT_MASK`, default 4'b0000, bit i = 1: key i is an E0-extended key
- `TIMEOUT`, default 16'd50000, max cycles allowed between prefix byte and its follow-up byte
- `clock` in 1: single clock domain
- `reset` in 1: synchronous, active-high
- `rx_data` in 8: received byte
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid
- `flag_clr` in 4: bit i clears `key_flag[i]`
- `key_down` out 4: level, key i currently held
- `key_press` out 4: one-cycle pulse on new press of key i
- `key_flag` out 4: sticky, set by press of key i
- `err` out 1: one-cycle pulse on protocol error or timeout

## Operation
- All outputs registered; reset values: `key_down`=0, `key_press`=0, `key_flag`=0, `err`=0, state=IDLE, timeout counter=0.
- States: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- IDLE: F0 -> BRK; E0 -> EXT; other byte = non-extended make code, match, stay IDLE.
- BRK: F0 or E0 -> IDLE, `err` pulse; other byte = non-extended break code, match, -> IDLE.
- EXT: F0 -> EXT_BRK; E0 -> IDLE, `err`; other = extended make, match, -> IDLE.
- EXT_BRK: F0 or E0 -> IDLE, `err`; other = extended break, match, -> IDLE.
- Match for key i: byte == KEYi and extended-ness == `EXT_MASK[i]`. Several keys may share a code only if they differ in `EXT_MASK`; identical code+mask sets all matching bits.
- Make of key i: if `key_down[i]`=0 -> `key_down[i]`←1, `key_press[i]` pulse, `key_flag[i]`←1. If already down (typematic repeat) -> no pulse, no flag change.
- Break of key i: `key_down[i]`←0; no pulse. Break of key not down: no effect, no error.
- Unmatched complete codes: consumed silently.
- `flag_clr[i]` clears `key_flag[i]`; same-cycle set and clear -> set wins.
- Timeout: counter runs only in BRK/EXT/EXT_BRK, cleared on every `rx_valid` and on entering IDLE. Reaching `TIMEOUT` without a byte -> IDLE, `err` pulse, outputs otherwise unchanged.
- `rx_valid` ignored in no state; every strobe consumed.

## Timing
- Byte with `rx_valid` in cycle N -> state, `key_down`, `key_press`, `key_flag`, `err` updated at clock edge ending cycle N, visible in cycle N+1.
- `key_press` and `err` high exactly one cycle.
- Back-to-back `rx_valid` every cycle supported.
- `flag_clr` takes effect next cycle.
- Timeout: `err` visible in cycle where counter equals `TIMEOUT`, i.e. `TIMEOUT` cycles after last byte.
- Reset mid-sequence (e.g. in BRK): next cycle all outputs 0, state IDLE; following byte decoded as fresh.

## Configuration
- `KEY_EVENT_EXT_EN` defined: E0 prefix handled as above; EXT and EXT_BRK states present; `EXT_MASK` honoured.
- Not defined: EXT/EXT_BRK removed; E0 in IDLE discarded (stay IDLE, no error), in BRK -> IDLE with `err`; all keys matched as non-extended, `EXT_MASK` ignored.

## Test plan
- Reset, send 3C -> `key_press`=0001 one cycle, `key_down`=0001, `key_flag`=0001.
- Then 3C again, then F0 3C -> no second pulse; after break `key_down`=0000, `key_flag` stays 0001; pulse `flag_clr`=0001 -> `key_flag`=0000.
- `flag_clr`=0010 in same cycle as 1C make -> `key_flag[1]`=1 (set wins).
- Send F0 then no byte for `TIMEOUT` cycles -> `err` one pulse, state IDLE; then 23 -> `key_press`=0100.
- With `KEY_EVENT_EXT_EN`, `EXT_MASK`=1000, KEY3=8'h75: E0 75 -> `key_press`=1000; plain 75 -> no response; E0 F0 75 -> `key_down[3]`=0.
- Send F0 F0 -> `err` pulse; reset asserted after E0 -> all outputs 0, next 2D decoded as non-extended.
